// File: rtl/wb_pkg.sv
// Shared types and default widths for the MEM/WB boundary buffer.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_REG_AW = 5;

  // One instruction slot of a writeback packet
  typedef struct packed {
    logic                 reg_write;
    logic                 mem_2_reg;
    logic [WB_REG_AW-1:0] rd;
    logic [WB_DATA_W-1:0] alu_data;
    logic [WB_DATA_W-1:0] mem_data;
  } wb_lane_t;

  // Occupancy of the head/skid pair
  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } wb_count_e;

endpackage

// File: rtl/wb_waw_filter.sv
// Per-packet write-enable gating: drops rd==0 writes and older-lane writes
// shadowed by a younger lane targeting the same register.
module wb_waw_filter
  import wb_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned REG_AW = WB_REG_AW
) (
  input  logic [LANES-1:0]        reg_write,
  input  logic [LANES*REG_AW-1:0] rd,
  output logic [LANES-1:0]        reg_write_c
);

  // Younger (higher) lane wins a same-packet WAW
  always_comb begin
    reg_write_c = reg_write;
    for (int i = 0; i < LANES; i++) begin
      if (rd[i*REG_AW +: REG_AW] == '0) reg_write_c[i] = 1'b0;
      for (int j = i + 1; j < LANES; j++) begin
        if (reg_write[j] && (rd[j*REG_AW +: REG_AW] == rd[i*REG_AW +: REG_AW]))
          reg_write_c[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_stage_buf.sv
// MEM/WB boundary: LANES-wide packets, valid/ready with a 2-entry skid buffer,
// write-enable gating and the final writeback mux.
// Optional macro WB_PERF_CNT_EN adds perf_retired / perf_stall counters.
module wb_stage_buf
  import wb_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned REG_AW = WB_REG_AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_reg_write,
  input  logic [LANES-1:0]         in_mem_2_reg,
  input  logic [LANES*REG_AW-1:0]  in_rd,
  input  logic [LANES*DATA_W-1:0]  in_alu_data,
  input  logic [LANES*DATA_W-1:0]  in_mem_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0]         out_reg_write,
  output logic [LANES*REG_AW-1:0]  out_rd,
  output logic [LANES*DATA_W-1:0]  out_wb_data
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]              perf_retired,
  output logic [31:0]              perf_stall
`endif
);

  wb_count_e                count;
  logic [LANES-1:0]         head_we, head_m2r, skid_we, skid_m2r;
  logic [LANES*REG_AW-1:0]  head_rd, skid_rd;
  logic [LANES*DATA_W-1:0]  head_alu, head_mem, skid_alu, skid_mem;
  logic [LANES-1:0]         in_we_c;
  logic                     accept, pop;

  wb_waw_filter #(.LANES(LANES), .REG_AW(REG_AW)) u_waw (
    .reg_write   (in_reg_write),
    .rd          (in_rd),
    .reg_write_c (in_we_c)
  );

  assign in_ready      = (count != CNT_FULL);
  assign out_valid     = (count != CNT_EMPTY);
  assign accept        = in_valid & in_ready & ~flush;
  assign pop           = out_valid & out_ready;
  assign out_reg_write = head_we & {LANES{out_valid}};
  assign out_rd        = head_rd;

  // Writeback source select per lane from the head entry
  always_comb begin
    out_wb_data = '0;
    for (int i = 0; i < LANES; i++)
      out_wb_data[i*DATA_W +: DATA_W] = head_m2r[i] ? head_mem[i*DATA_W +: DATA_W]
                                                     : head_alu[i*DATA_W +: DATA_W];
  end

  // Occupancy FSM and head/skid storage
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= CNT_EMPTY;
      head_we  <= '0; head_m2r <= '0; head_rd <= '0; head_alu <= '0; head_mem <= '0;
      skid_we  <= '0; skid_m2r <= '0; skid_rd <= '0; skid_alu <= '0; skid_mem <= '0;
    end else if (flush) begin
      count   <= CNT_EMPTY;
      head_we <= '0;
      skid_we <= '0;
    end else begin
      case (count)
        CNT_EMPTY: begin
          if (accept) begin
            head_we <= in_we_c; head_m2r <= in_mem_2_reg; head_rd <= in_rd;
            head_alu <= in_alu_data; head_mem <= in_mem_data;
            count <= CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (accept && !pop) begin
            skid_we <= in_we_c; skid_m2r <= in_mem_2_reg; skid_rd <= in_rd;
            skid_alu <= in_alu_data; skid_mem <= in_mem_data;
            count <= CNT_FULL;
          end else if (accept && pop) begin
            head_we <= in_we_c; head_m2r <= in_mem_2_reg; head_rd <= in_rd;
            head_alu <= in_alu_data; head_mem <= in_mem_data;
          end else if (pop) begin
            count <= CNT_EMPTY;
          end
        end
        CNT_FULL: begin
          if (pop) begin
            head_we <= skid_we; head_m2r <= skid_m2r; head_rd <= skid_rd;
            head_alu <= skid_alu; head_mem <= skid_mem;
            count <= CNT_ONE;
          end
        end
        default: count <= CNT_EMPTY;
      endcase
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] retire_inc_c;

  // Number of lanes actually written by the head packet
  always_comb begin
    retire_inc_c = '0;
    for (int i = 0; i < LANES; i++)
      retire_inc_c = retire_inc_c + 32'(out_reg_write[i]);
  end

  // Free-running perf counters; survive flush
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) perf_retired <= perf_retired + retire_inc_c;
      if (in_valid && !in_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Directed bench for wb_stage_buf (two lanes, default widths).
module tb_wb_stage_buf;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_reg_write, in_mem_2_reg, out_reg_write;
  logic [9:0]  in_rd, out_rd;
  logic [63:0] in_alu_data, in_mem_data, out_wb_data;
`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_retired, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage_buf dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_mem_2_reg(in_mem_2_reg), .in_rd(in_rd),
    .in_alu_data(in_alu_data), .in_mem_data(in_mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_write(out_reg_write), .out_rd(out_rd), .out_wb_data(out_wb_data)
`ifdef WB_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input logic [1:0] we, input logic [1:0] m2r,
                           input logic [4:0] rd0, input logic [4:0] rd1,
                           input logic [31:0] alu0, input logic [31:0] alu1,
                           input logic [31:0] mem0, input logic [31:0] mem1);
    in_reg_write = we;
    in_mem_2_reg = m2r;
    in_rd        = {rd1, rd0};
    in_alu_data  = {alu1, alu0};
    in_mem_data  = {mem1, mem0};
  endtask

  // Packet k for ordering tests: lane0 alu 0x10+k, lane1 mem 0x20+k
  task automatic drive_num(input int k);
    drive_pkt(2'b11, 2'b10, 5'd1, 5'd2, 32'h10 + 32'(k), 32'hDEAD, 32'hBEEF, 32'h20 + 32'(k));
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive_pkt(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_reg_write !== 2'b00) begin errors++; $display("FAIL reset_reg_write: got %b want 00", out_reg_write); end
    checks++; if (out_wb_data !== 64'h0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", out_wb_data); end
    checks++; if (out_rd !== 10'h0) begin errors++; $display("FAIL reset_rd: got %h want 0", out_rd); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    drive_pkt(2'b11, 2'b10, 5'd3, 5'd4, 32'h11, 32'h0, 32'h0, 32'hAB);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (out_wb_data !== {32'hAB, 32'h11}) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", k, out_wb_data, {32'hAB, 32'h11}); end
      checks++; if (out_reg_write !== 2'b11 || out_rd !== {5'd4, 5'd3}) begin errors++; $display("FAIL stream_we_rd[%0d]: got %b/%h want 11/%h", k, out_reg_write, out_rd, {5'd4, 5'd3}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", k, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive_num(0); tick();
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_one: got valid %b ready %b want 1 1", out_valid, in_ready); end
    drive_num(1); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got in_ready %b want 0", in_ready); end
    drive_num(2); tick();
    checks++; if (in_ready !== 1'b0 || out_wb_data !== {32'h20, 32'h10}) begin errors++; $display("FAIL bp_hold: got ready %b data %h want 0 %h", in_ready, out_wb_data, {32'h20, 32'h10}); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_wb_data !== {32'h21, 32'h11} || in_ready !== 1'b1) begin errors++; $display("FAIL bp_p1: got data %h ready %b want %h 1", out_wb_data, in_ready, {32'h21, 32'h11}); end
    tick();
    checks++; if (out_wb_data !== {32'h22, 32'h12} || out_valid !== 1'b1) begin errors++; $display("FAIL bp_p2: got data %h valid %b want %h 1", out_wb_data, out_valid, {32'h22, 32'h12}); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_waw();
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive_pkt(2'b11, 2'b00, 5'd7, 5'd7, 32'h1, 32'h2, 32'h0, 32'h0); tick();
    checks++; if (out_reg_write !== 2'b10) begin errors++; $display("FAIL waw_same_rd: got %b want 10", out_reg_write); end
    drive_pkt(2'b11, 2'b00, 5'd0, 5'd5, 32'h1, 32'h2, 32'h0, 32'h0); tick();
    checks++; if (out_reg_write !== 2'b10) begin errors++; $display("FAIL waw_rd0: got %b want 10", out_reg_write); end
    drive_pkt(2'b11, 2'b00, 5'd5, 5'd6, 32'h1, 32'h2, 32'h0, 32'h0); tick();
    checks++; if (out_reg_write !== 2'b11) begin errors++; $display("FAIL waw_distinct: got %b want 11", out_reg_write); end
    drive_pkt(2'b01, 2'b00, 5'd3, 5'd3, 32'h1, 32'h2, 32'h0, 32'h0); tick();
    checks++; if (out_reg_write !== 2'b01) begin errors++; $display("FAIL waw_young_off: got %b want 01", out_reg_write); end
    in_valid = 1'b0; tick();
    checks++; if (out_reg_write !== 2'b00) begin errors++; $display("FAIL waw_idle_gate: got %b want 00", out_reg_write); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive_num(1); tick();
    drive_num(2); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefill: got in_ready %b want 0", in_ready); end
    drive_num(9); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_reg_write !== 2'b00 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: got valid %b we %b ready %b want 0 00 1", out_valid, out_reg_write, in_ready); end
    out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive_num(3); tick();
    drive_num(4); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_prefill: got in_ready %b want 0", in_ready); end
    tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_reg_write !== 2'b00 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_stall_ctl: got valid %b we %b ready %b want 0 00 1", out_valid, out_reg_write, in_ready); end
    checks++; if (out_rd !== 10'h0 || out_wb_data !== 64'h0) begin errors++; $display("FAIL rst_stall_data: got rd %h data %h want 0 0", out_rd, out_wb_data); end
`ifdef WB_PERF_CNT_EN
    checks++; if (perf_retired !== 32'd0 || perf_stall !== 32'd0) begin errors++; $display("FAIL rst_perf: got %0d %0d want 0 0", perf_retired, perf_stall); end
`endif
    out_ready = 1'b1; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_empty: got valid %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_waw();
    test_flush();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
